mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single RAM port between the instruction-cache refill path and the data-cache/load-store path.
- Sequences multi-word line refills: per-beat address generation and word forwarding to the owning requester.
- Round-robin on contention; a granted burst is never preempted.
- Sits between the fetch unit and data memory stage on one side and the RAM interface on the other.

Parameters:
ADDR_W, 32, address width in bits
DATA_W, 32, RAM word width in bits
LINE_WORDS, 4, words per cache-line refill; power of two, at least 2

Ports:
clk  in  1  clock
nrst  in  1  reset, synchronous, active-low
i_req  in  1  icache refill request; held until i_done
i_addr  in  ADDR_W  icache miss address; line-aligned internally
i_word  out  DATA_W  refill word to icache
i_word_valid  out  1  i_word valid this cycle
i_done  out  1  one-cycle pulse with last icache word
d_req  in  1  data-side request; held until d_done
d_we  in  1  1 = single-word write, 0 = line read
d_addr  in  ADDR_W  data address; line-aligned for reads, word-aligned for writes
d_wdata  in  DATA_W  write data
d_word  out  DATA_W  read word to dcache
d_word_valid  out  1  d_word valid this cycle
d_done  out  1  one-cycle pulse: last read word, or write accepted
ram_req  out  1  RAM access request
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM byte address
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data, valid with ram_ready
ram_ready  in  1  RAM beat complete
owner  out  2  00 idle, 01 icache, 10 data

Behaviour:
- FSM states: IDLE, SERVE_I, SERVE_D. Reset forces IDLE, beat counter 0, last_served = D.
- Reset values: every output 0.
- Reset mid-burst aborts the burst; no done pulse is produced.

IDLE:
- i_req only -> SERVE_I.
- d_req only -> SERVE_D.
- Both -> grant the requester that was not last_served. First tie after reset goes to icache.
- Grant takes effect next cycle.
- At grant, latch base address, d_we and d_wdata. Read base address has its low log2(LINE_WORDS)+2 bits cleared. Write address has its low 2 bits cleared.

SERVE_x:
- ram_req = 1. ram_addr = base + 4*beat, mod 2^ADDR_W.
- ram_addr, ram_we and ram_wdata stay stable until ram_ready.
- ram_we = 1 only in SERVE_D with latched d_we = 1.
- On ram_ready, the beat counter increments. ram_ready is ignored while ram_req = 0.
- Read: the cycle after each ram_ready, x_word is the registered ram_rdata and x_word_valid = 1 for exactly one cycle.
- On the last beat (beat = LINE_WORDS-1), x_done pulses in the same cycle as the last x_word_valid.
- Write: one beat only. x_done pulses the cycle after ram_ready; x_word_valid stays 0.
- After the last ram_ready: ram_req drops, the FSM goes to IDLE, last_served is updated.
- There is always at least one IDLE cycle between bursts, so back-to-back ram_req is never asserted across owners.
- Requester input changes during a burst (req deassert, address change) are ignored. The burst always completes.
- Back-to-back ram_ready on consecutive cycles gives 1 word/cycle throughput.
- owner reflects the state: 01 in SERVE_I, 10 in SERVE_D, 00 in IDLE.

Test Plan:
- Icache refill: i_req with i_addr = 0x0000_0014, ram_ready every cycle -> ram_addr 0x10, 0x14, 0x18, 0x1C. i_word_valid for 4 consecutive cycles. i_done with 4th word. owner 01 then 00.
- Simultaneous i_req and d_req (read, d_addr = 0x100) right after reset -> icache served first. Data burst starts after the one IDLE cycle. Next simultaneous tie goes to icache again, since data was last served.
- Data write: d_we = 1, d_addr = 0x203, d_wdata = 0xDEADBEEF, ram_ready after 3 wait cycles -> ram_addr 0x200, ram_we = 1, ram_wdata held 4 cycles. d_done one cycle after ram_ready. No d_word_valid.
- Wait states: ram_ready low for 5 cycles on beat 2 -> ram_addr holds base+8 throughout, no spurious valid. Remaining beats complete normally.
- Wrap: i_addr = 0xFFFF_FFF4 -> addresses 0xFFFFFFF0, 0xFFFFFFF4, 0xFFFFFFF8, 0xFFFFFFFC. No overflow into the next line.
- Reset mid-burst: nrst low after beat 1 -> next cycle all outputs 0, owner 00, no i_done. A fresh i_req restarts from beat 0.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the icache refill, data-side and RAM signals around the RAM port arbiter.
// master: the arbiter's view; slave: the view of the requesters and the RAM.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    // icache refill side
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_word;
    logic              i_word_valid;
    logic              i_done;
    // data / load-store side
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_word;
    logic              d_word_valid;
    logic              d_done;
    // RAM side
    logic              ram_req;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              ram_ready;
    // current grant: 00 idle, 01 icache, 10 data
    logic [1:0]        owner;

    modport master (
        input  i_req, i_addr,
        output i_word, i_word_valid, i_done,
        input  d_req, d_we, d_addr, d_wdata,
        output d_word, d_word_valid, d_done,
        output ram_req, ram_we, ram_addr, ram_wdata,
        input  ram_rdata, ram_ready,
        output owner
    );

    modport slave (
        output i_req, i_addr,
        input  i_word, i_word_valid, i_done,
        output d_req, d_we, d_addr, d_wdata,
        input  d_word, d_word_valid, d_done,
        input  ram_req, ram_we, ram_addr, ram_wdata,
        output ram_rdata, ram_ready,
        input  owner
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one RAM port between icache line refills and data-side line reads / single-word writes.
// Round-robin on ties, bursts run to completion, at least one idle cycle between bursts.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic               clk,
    input  logic               nrst,
    mem_port_arbiter_if.master bus
);

    localparam int unsigned BEAT_W    = $clog2(LINE_WORDS);
    localparam int unsigned LINE_MASK = LINE_WORDS * 4 - 1;

    // encoding doubles as the owner code
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        SERVE_I = 2'b01,
        SERVE_D = 2'b10
    } state_t;

    state_t              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic                we_q, we_d;
    logic                last_d_q, last_d_d;     // 1 = data side was served last
    logic                ram_req_q, ram_req_d;
    logic                ram_we_q, ram_we_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
    logic [DATA_W-1:0]   i_word_q, i_word_d;
    logic                i_valid_q, i_valid_d;
    logic                i_done_q, i_done_d;
    logic [DATA_W-1:0]   d_word_q, d_word_d;
    logic                d_valid_q, d_valid_d;
    logic                d_done_q, d_done_d;

    logic                want_i, want_d, last_beat;
    logic [ADDR_W-1:0]   i_line, d_line, d_word_addr;

    // a request seen together with its own done pulse is stale and must not restart a burst
    assign want_i      = bus.i_req && !i_done_q;
    assign want_d      = bus.d_req && !d_done_q;
    assign i_line      = bus.i_addr & ~ADDR_W'(LINE_MASK);
    assign d_line      = bus.d_addr & ~ADDR_W'(LINE_MASK);
    assign d_word_addr = bus.d_addr & ~ADDR_W'(3);

    // next-state, arbitration and beat sequencing
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        base_d      = base_q;
        we_d        = we_q;
        last_d_d    = last_d_q;
        ram_req_d   = ram_req_q;
        ram_we_d    = ram_we_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        i_word_d    = i_word_q;
        i_valid_d   = 1'b0;
        i_done_d    = 1'b0;
        d_word_d    = d_word_q;
        d_valid_d   = 1'b0;
        d_done_d    = 1'b0;
        last_beat   = we_q || (beat_q == BEAT_W'(LINE_WORDS - 1));

        unique case (state_q)
            IDLE: begin
                if (want_i && (!want_d || last_d_q)) begin
                    state_d    = SERVE_I;
                    beat_d     = '0;
                    base_d     = i_line;
                    we_d       = 1'b0;
                    ram_req_d  = 1'b1;
                    ram_we_d   = 1'b0;
                    ram_addr_d = i_line;
                end else if (want_d) begin
                    state_d     = SERVE_D;
                    beat_d      = '0;
                    base_d      = bus.d_we ? d_word_addr : d_line;
                    we_d        = bus.d_we;
                    ram_req_d   = 1'b1;
                    ram_we_d    = bus.d_we;
                    ram_addr_d  = bus.d_we ? d_word_addr : d_line;
                    ram_wdata_d = bus.d_wdata;
                end
            end
            SERVE_I, SERVE_D: begin
                if (bus.ram_ready) begin
                    if (state_q == SERVE_I) begin
                        i_word_d  = bus.ram_rdata;
                        i_valid_d = 1'b1;
                        i_done_d  = last_beat;
                    end else begin
                        if (!we_q) begin
                            d_word_d  = bus.ram_rdata;
                            d_valid_d = 1'b1;
                        end
                        d_done_d = last_beat;
                    end
                    if (last_beat) begin
                        state_d   = IDLE;
                        beat_d    = '0;
                        ram_req_d = 1'b0;
                        ram_we_d  = 1'b0;
                        last_d_d  = (state_q == SERVE_D);
                    end else begin
                        beat_d     = beat_q + BEAT_W'(1);
                        ram_addr_d = base_q + (ADDR_W'(beat_q + BEAT_W'(1)) << 2);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state and output registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            base_q      <= '0;
            we_q        <= 1'b0;
            last_d_q    <= 1'b1;
            ram_req_q   <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            i_word_q    <= '0;
            i_valid_q   <= 1'b0;
            i_done_q    <= 1'b0;
            d_word_q    <= '0;
            d_valid_q   <= 1'b0;
            d_done_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            base_q      <= base_d;
            we_q        <= we_d;
            last_d_q    <= last_d_d;
            ram_req_q   <= ram_req_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            i_word_q    <= i_word_d;
            i_valid_q   <= i_valid_d;
            i_done_q    <= i_done_d;
            d_word_q    <= d_word_d;
            d_valid_q   <= d_valid_d;
            d_done_q    <= d_done_d;
        end
    end

    assign bus.i_word       = i_word_q;
    assign bus.i_word_valid = i_valid_q;
    assign bus.i_done       = i_done_q;
    assign bus.d_word       = d_word_q;
    assign bus.d_word_valid = d_valid_q;
    assign bus.d_done       = d_done_q;
    assign bus.ram_req      = ram_req_q;
    assign bus.ram_we       = ram_we_q;
    assign bus.ram_addr     = ram_addr_q;
    assign bus.ram_wdata    = ram_wdata_q;
    assign bus.owner        = 2'(state_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: transaction-level reference model checked every cycle,
// plus hand-computed address/timing expectations per scenario.
module tb_mem_port_arbiter;

    localparam int unsigned LW = 4;

    logic clk;
    logic nrst;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LINE_WORDS(LW)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus.master)
    );

    int checks = 0;
    int errors = 0;

    // RAM agent controls
    int wait_beat[4] = '{0, 0, 0, 0};
    bit spurious     = 1'b0;

    // reference model state (what the outputs must be after the most recent edge)
    bit          model_ok = 1'b0;
    logic [1:0]  m_owner, m_last;
    int          m_beat, m_len;
    logic [31:0] m_base, m_wdata, m_iw, m_dw;
    bit          m_we, m_iv, m_id, m_dv, m_dd;

    // observation logs
    int          cyc = 0;
    int          acc_cyc = -1;
    logic [31:0] addr_log[$];
    logic [31:0] grant_log[$];
    int          gcyc_log[$];
    int          iv_log[$];
    int          id_cnt, id_cyc, dv_cnt, dd_cyc, wd_cnt, hold_cnt;

    function automatic logic [31:0] ram_f(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hEEEE_EEEE;
    endfunction

    task automatic clear_logs();
        addr_log.delete();
        grant_log.delete();
        gcyc_log.delete();
        iv_log.delete();
        id_cnt = 0; id_cyc = -1; dv_cnt = 0; dd_cyc = -1; wd_cnt = 0; hold_cnt = 0;
        acc_cyc = -1;
    endtask

    task automatic do_i(input logic [31:0] a);
        bit seen;
        seen = 1'b0;
        bus.i_req  = 1'b1;
        bus.i_addr = a;
        for (int k = 0; k < 300 && !seen; k++) begin
            @(negedge clk);
            if (bus.i_done) seen = 1'b1;
        end
        bus.i_req = 1'b0;
        chk("i_done_seen", 32'(seen), 32'd1);
    endtask

    task automatic do_d(input bit we, input logic [31:0] a, input logic [31:0] wd);
        bit seen;
        seen = 1'b0;
        bus.d_req   = 1'b1;
        bus.d_we    = we;
        bus.d_addr  = a;
        bus.d_wdata = wd;
        for (int k = 0; k < 300 && !seen; k++) begin
            @(negedge clk);
            if (bus.d_done) seen = 1'b1;
        end
        bus.d_req = 1'b0;
        chk("d_done_seen", 32'(seen), 32'd1);
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // reference model: burst-level view of the arbiter, stepped on each active edge
    initial begin
        bit prev_id, prev_dd, gi, gd;
        logic [31:0] a;
        forever begin
            @(posedge clk);
            prev_id = m_id;
            prev_dd = m_dd;
            m_iv = 0; m_id = 0; m_dv = 0; m_dd = 0;
            if (!nrst) begin
                model_ok = 1'b1;
                m_owner = 2'd0; m_last = 2'd2; m_beat = 0; m_len = 0;
                m_base = 0; m_wdata = 0; m_we = 0; m_iw = 0; m_dw = 0;
            end else if (m_owner == 2'd0) begin
                gi = bus.i_req && !prev_id;
                gd = bus.d_req && !prev_dd;
                m_beat = 0;
                if (gi && (!gd || m_last == 2'd2)) begin
                    m_owner = 2'd1; m_we = 0; m_len = LW;
                    m_base = bus.i_addr - (bus.i_addr % (LW * 4));
                end else if (gd) begin
                    m_owner = 2'd2; m_we = bus.d_we; m_wdata = bus.d_wdata;
                    m_len   = bus.d_we ? 1 : LW;
                    m_base  = bus.d_we ? bus.d_addr - (bus.d_addr % 4)
                                       : bus.d_addr - (bus.d_addr % (LW * 4));
                end
            end else if (bus.ram_ready) begin
                a = m_base + 32'(4 * m_beat);
                if (m_owner == 2'd1) begin
                    m_iv = 1; m_iw = ram_f(a);
                end else if (!m_we) begin
                    m_dv = 1; m_dw = ram_f(a);
                end
                m_beat++;
                if (m_beat == m_len) begin
                    if (m_owner == 2'd1) m_id = 1; else m_dd = 1;
                    m_last  = m_owner;
                    m_owner = 2'd0;
                end
            end
        end
    end

    // accepted-beat logger and cycle counter
    initial begin
        forever begin
            @(posedge clk);
            if (nrst && bus.ram_req && bus.ram_ready) begin
                addr_log.push_back(bus.ram_addr);
                acc_cyc = cyc;
            end
            cyc++;
        end
    end

    // RAM agent: per-beat wait states, optional ready pulses while no request is pending
    initial begin
        int wcnt, bidx;
        wcnt = 0; bidx = 0;
        bus.ram_ready = 1'b0;
        bus.ram_rdata = '0;
        forever begin
            @(negedge clk);
            if (bus.ram_req) begin
                if (wcnt >= wait_beat[bidx]) begin
                    bus.ram_ready = 1'b1;
                    bus.ram_rdata = ram_f(bus.ram_addr);
                    wcnt = 0;
                    bidx = (bidx + 1) % 4;
                end else begin
                    bus.ram_ready = 1'b0;
                    bus.ram_rdata = 32'hBAD0_BAD0;
                    wcnt++;
                end
            end else begin
                bus.ram_ready = spurious;
                bus.ram_rdata = 32'hBAD0_BAD0;
                wcnt = 0;
                bidx = 0;
            end
        end
    end

    // per-cycle comparison against the model, plus event logging
    initial begin
        logic [1:0] prev_own;
        prev_own = 2'd0;
        forever begin
            @(negedge clk);
            if (model_ok) begin
                chk("owner", 32'(bus.owner), 32'(m_owner));
                chk("ram_req", 32'(bus.ram_req), 32'(m_owner != 2'd0));
                if (bus.ram_req) begin
                    chk("ram_addr", bus.ram_addr, m_base + 32'(4 * m_beat));
                    chk("ram_we", 32'(bus.ram_we), 32'(m_owner == 2'd2 && m_we));
                    if (bus.ram_we) chk("ram_wdata", bus.ram_wdata, m_wdata);
                end
                chk("i_word_valid", 32'(bus.i_word_valid), 32'(m_iv));
                chk("i_done", 32'(bus.i_done), 32'(m_id));
                chk("i_word", bus.i_word, m_iw);
                chk("d_word_valid", 32'(bus.d_word_valid), 32'(m_dv));
                chk("d_done", 32'(bus.d_done), 32'(m_dd));
                chk("d_word", bus.d_word, m_dw);
            end
            if (bus.owner != 2'd0 && prev_own == 2'd0) begin
                grant_log.push_back(32'(bus.owner));
                gcyc_log.push_back(cyc);
            end
            prev_own = bus.owner;
            if (bus.i_word_valid) iv_log.push_back(cyc);
            if (bus.i_done) begin id_cnt++; id_cyc = cyc; end
            if (bus.d_word_valid) dv_cnt++;
            if (bus.d_done) dd_cyc = cyc;
            if (bus.ram_req && bus.ram_we && bus.ram_wdata == 32'hDEAD_BEEF) wd_cnt++;
            if (bus.ram_req && bus.ram_addr == 32'h0000_0308) hold_cnt++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        nrst        = 1'b0;
        bus.i_req   = 1'b0;
        bus.i_addr  = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        clear_logs();
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_owner", 32'(bus.owner), 32'd0);
        chk("rst_ram_req", 32'(bus.ram_req), 32'd0);
        chk("rst_ram_addr", bus.ram_addr, 32'd0);
        chk("rst_i_done", 32'(bus.i_done), 32'd0);
        nrst = 1'b1;
        @(negedge clk);

        // first tie after reset goes to icache, data follows after one idle cycle
        clear_logs();
        fork
            do_i(32'h0000_0040);
            do_d(1'b0, 32'h0000_0100, 32'h0);
        join
        chk("tie1_n", 32'(grant_log.size()), 32'd2);
        chk("tie1_first", q_at(grant_log, 0), 32'd1);
        chk("tie1_second", q_at(grant_log, 1), 32'd2);
        chk("tie1_gap", 32'(gcyc_log.size() > 1 ? gcyc_log[1] : -1), 32'(id_cyc + 1));
        chk("tie1_d_beat0", q_at(addr_log, 4), 32'h0000_0100);
        repeat (2) @(negedge clk);

        // data was last served, so the next tie is icache again
        clear_logs();
        fork
            do_i(32'h0000_0080);
            do_d(1'b0, 32'h0000_0184, 32'h0);
        join
        chk("tie2_first", q_at(grant_log, 0), 32'd1);
        chk("tie2_second", q_at(grant_log, 1), 32'd2);
        chk("tie2_d_beat0", q_at(addr_log, 4), 32'h0000_0180);
        repeat (2) @(negedge clk);

        // icache refill from an unaligned miss, with stray ready pulses while idle
        clear_logs();
        spurious = 1'b1;
        @(negedge clk);
        do_i(32'h0000_0014);
        spurious = 1'b0;
        chk("ref_a0", q_at(addr_log, 0), 32'h0000_0010);
        chk("ref_a1", q_at(addr_log, 1), 32'h0000_0014);
        chk("ref_a2", q_at(addr_log, 2), 32'h0000_0018);
        chk("ref_a3", q_at(addr_log, 3), 32'h0000_001C);
        chk("ref_nvalid", 32'(iv_log.size()), 32'd4);
        chk("ref_consec", 32'(iv_log.size() == 4 ? iv_log[3] - iv_log[0] : -1), 32'd3);
        chk("ref_done_last", 32'(id_cyc), 32'(iv_log.size() == 4 ? iv_log[3] : -1));
        @(negedge clk);
        chk("ref_owner_after", 32'(bus.owner), 32'd0);
        repeat (2) @(negedge clk);

        // single-word write with three wait states
        clear_logs();
        wait_beat[0] = 3;
        do_d(1'b1, 32'h0000_0203, 32'hDEAD_BEEF);
        wait_beat[0] = 0;
        chk("wr_n", 32'(addr_log.size()), 32'd1);
        chk("wr_addr", q_at(addr_log, 0), 32'h0000_0200);
        chk("wr_hold", 32'(wd_cnt), 32'd4);
        chk("wr_done_lat", 32'(dd_cyc), 32'(acc_cyc + 1));
        chk("wr_no_valid", 32'(dv_cnt), 32'd0);
        repeat (2) @(negedge clk);

        // five wait states on beat 2
        clear_logs();
        wait_beat[2] = 5;
        do_i(32'h0000_0300);
        wait_beat[2] = 0;
        chk("ws_hold", 32'(hold_cnt), 32'd6);
        chk("ws_nvalid", 32'(iv_log.size()), 32'd4);
        chk("ws_a3", q_at(addr_log, 3), 32'h0000_030C);
        repeat (2) @(negedge clk);

        // address wrap at the top of the address space stays inside the line
        clear_logs();
        do_i(32'hFFFF_FFF4);
        chk("wrap_a0", q_at(addr_log, 0), 32'hFFFF_FFF0);
        chk("wrap_a1", q_at(addr_log, 1), 32'hFFFF_FFF4);
        chk("wrap_a2", q_at(addr_log, 2), 32'hFFFF_FFF8);
        chk("wrap_a3", q_at(addr_log, 3), 32'hFFFF_FFFC);
        repeat (2) @(negedge clk);

        // reset in the middle of a refill
        clear_logs();
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h0000_0088;
        for (int k = 0; k < 50 && addr_log.size() < 2; k++) @(negedge clk);
        chk("mid_beats", 32'(addr_log.size()), 32'd2);
        nrst      = 1'b0;
        bus.i_req = 1'b0;
        @(negedge clk);
        chk("mid_owner", 32'(bus.owner), 32'd0);
        chk("mid_ram_req", 32'(bus.ram_req), 32'd0);
        chk("mid_ram_addr", bus.ram_addr, 32'd0);
        chk("mid_i_word", bus.i_word, 32'd0);
        chk("mid_i_valid", 32'(bus.i_word_valid), 32'd0);
        nrst = 1'b1;
        @(negedge clk);
        chk("mid_no_done", 32'(id_cnt), 32'd0);
        clear_logs();
        do_i(32'h0000_0040);
        chk("rst_fresh_n", 32'(addr_log.size()), 32'd4);
        chk("rst_fresh_a0", q_at(addr_log, 0), 32'h0000_0040);
        chk("rst_fresh_a3", q_at(addr_log, 3), 32'h0000_004C);
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
